// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard controller: tracks the EXE/MEM producers and sequences
// stall, bubble, flush and freeze of the IF/ID and ID/EXE registers.
// Optional feature macro: ID_HAZARD_FORWARDING_EN (EXE forwarding present, so only
// a load immediately ahead of decode causes a stall).
module id_hazard_scoreboard #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_used,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic [3:0]       id_dest,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             stall,
  output logic             id_bubble,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic       wb;
    logic [3:0] dest;
    logic       ld;
  } sb_entry_t;

  sb_entry_t        r_e;
  sb_entry_t        r_m;
  logic [CNT_W-1:0] r_stall_cnt;

  logic      w_hit_e;
  logic      w_hit_m;
  logic      w_haz;
  logic      w_stall;
  logic      w_flush;
  logic      w_freeze;
  sb_entry_t w_e_next;
  logic      w_unused;

  // Does entry x produce a register the decode instruction is about to read?
  function automatic logic f_hit(sb_entry_t x, logic valid, logic s1_used, logic [3:0] s1,
                                 logic two_src, logic [3:0] s2);
    logic prod;
    prod  = x.v & x.wb;
    f_hit = valid & ((s1_used & prod & (x.dest == s1)) | (two_src & prod & (x.dest == s2)));
  endfunction

  // Hazard detection and output priority: reset > freeze > flush > stall.
  always_comb begin
    w_hit_e = f_hit(r_e, id_valid, id_src1_used, id_src1, id_two_src, id_src2);
    w_hit_m = f_hit(r_m, id_valid, id_src1_used, id_src1, id_two_src, id_src2);
`ifdef ID_HAZARD_FORWARDING_EN
    // Forwarding covers every ALU result and anything in MEM; only load-use stalls.
    w_haz    = w_hit_e & r_e.ld;
    w_unused = ^{w_hit_m, r_m};
`else
    w_haz    = w_hit_e | w_hit_m;
    w_unused = r_m.ld;
`endif
    w_freeze = rst & ~mem_ready;
    w_flush  = rst & branch_taken & mem_ready;
    w_stall  = rst & w_haz & mem_ready & ~branch_taken;
  end

  // Entry for the instruction leaving decode; a bubble when stalled or squashed.
  always_comb begin
    w_e_next      = r_e;
    w_e_next.v    = id_valid & ~w_stall & ~w_flush;
    w_e_next.wb   = id_wb_en;
    w_e_next.dest = id_dest;
    w_e_next.ld   = id_mem_read;
  end

  // Scoreboard shifts only on unfrozen cycles; stall counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e         <= '0;
      r_m         <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (mem_ready) begin
        r_m <= r_e;
        r_e <= w_e_next;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign flush     = w_flush;
  assign freeze    = w_freeze;
  assign id_bubble = w_stall | w_flush;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Randomised bench for id_hazard_scoreboard with a reference model of the
// in-flight instruction history and a queue-based scoreboard monitor.
module tb_id_hazard_scoreboard;

  localparam int unsigned CntW = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [3:0]      id_src1;
  logic            id_src1_used;
  logic [3:0]      id_src2;
  logic            id_two_src;
  logic            id_wb_en;
  logic [3:0]      id_dest;
  logic            id_mem_read;
  logic            branch_taken;
  logic            mem_ready;
  logic            stall;
  logic            id_bubble;
  logic            flush;
  logic            freeze;
  logic [CntW-1:0] stall_cnt;

  id_hazard_scoreboard #(.CNT_W(CntW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src1_used (id_src1_used),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .id_mem_read  (id_mem_read),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .id_bubble    (id_bubble),
    .flush        (flush),
    .freeze       (freeze),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n;
    bit       valid;
    bit       s1_used;
    bit [3:0] s1;
    bit       two_src;
    bit [3:0] s2;
    bit       wb;
    bit [3:0] dest;
    bit       ld;
    bit       bt;
    bit       mr;
  } stim_t;

  // An instruction that has left decode (or a bubble, when real == 0).
  typedef struct {
    bit       real_insn;
    bit       wb;
    bit [3:0] dest;
    bit       ld;
  } insn_t;

  typedef struct {
    bit stall;
    bit bubble;
    bit flush;
    bit freeze;
    int cnt;
    int cyc;
  } exp_t;

  exp_t  exp_q[$];
  insn_t ahead[$];  // ahead[0] is in EXE, ahead[1] in MEM
  int    model_cnt;
  int    n_checks;
  int    n_errors;
  int    cyc;

  function automatic stim_t mk(bit valid, bit s1_used, bit [3:0] s1, bit two_src, bit [3:0] s2,
                               bit wb, bit [3:0] dest, bit ld, bit bt, bit mr);
    stim_t s;
    s.rst_n = 1'b1; s.valid = valid; s.s1_used = s1_used; s.s1 = s1;
    s.two_src = two_src; s.s2 = s2; s.wb = wb; s.dest = dest; s.ld = ld;
    s.bt = bt; s.mr = mr;
    return s;
  endfunction

  // Does the decode instruction read what producer p writes?
  function automatic bit reads(stim_t s, insn_t p);
    if (!s.valid || !p.real_insn || !p.wb) return 1'b0;
    return (s.s1_used && p.dest == s.s1) || (s.two_src && p.dest == s.s2);
  endfunction

  function automatic bit hazard(stim_t s);
`ifdef ID_HAZARD_FORWARDING_EN
    return reads(s, ahead[0]) && ahead[0].ld;
`else
    return reads(s, ahead[0]) || reads(s, ahead[1]);
`endif
  endfunction

  task automatic step(input stim_t s);
    exp_t  e;
    insn_t n;
    @(posedge clk);
    #1;
    rst = s.rst_n; id_valid = s.valid; id_src1_used = s.s1_used; id_src1 = s.s1;
    id_two_src = s.two_src; id_src2 = s.s2; id_wb_en = s.wb; id_dest = s.dest;
    id_mem_read = s.ld; branch_taken = s.bt; mem_ready = s.mr;
    e = '{default: 0};
    e.cyc = cyc;
    e.cnt = model_cnt;
    if (s.rst_n) begin
      e.freeze = !s.mr;
      e.flush  = s.mr && s.bt;
      e.stall  = s.mr && !s.bt && hazard(s);
      e.bubble = e.stall || e.flush;
    end
    exp_q.push_back(e);
    // Advance the model to the state after this clock edge.
    if (!s.rst_n) begin
      ahead = '{'{0, 0, 4'd0, 0}, '{0, 0, 4'd0, 0}};
      model_cnt = 0;
    end else begin
      if (s.mr) begin
        n.real_insn = s.valid && !e.stall && !e.flush;
        n.wb = s.wb; n.dest = s.dest; n.ld = s.ld;
        ahead.push_front(n);
        void'(ahead.pop_back());
      end
      if (e.stall && model_cnt < CntMax) model_cnt++;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int req, input int c);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d, required %0d", name, c, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a response; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", int'(stall), int'(e.stall), e.cyc);
      chk("id_bubble", int'(id_bubble), int'(e.bubble), e.cyc);
      chk("flush", int'(flush), int'(e.flush), e.cyc);
      chk("freeze", int'(freeze), int'(e.freeze), e.cyc);
      chk("stall_cnt", int'(stall_cnt), e.cnt, e.cyc);
    end
  end

  stim_t s_rst;
  stim_t s_nop;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; model_cnt = 0;
    ahead = '{'{0, 0, 4'd0, 0}, '{0, 0, 4'd0, 0}};
    rst = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src1_used = 1'b0; id_src2 = '0;
    id_two_src = 1'b0; id_wb_en = 1'b0; id_dest = '0; id_mem_read = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1;
    s_nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    s_rst = s_nop;
    s_rst.rst_n = 1'b0;

    step(s_rst);
    step(s_rst);
    // ALU RAW: ADD R1 then SUB R2,R1,R3 held in decode until it issues.
    step(mk(1, 1, 4'd5, 1, 4'd6, 1, 4'd1, 0, 0, 1));
    repeat (4) step(mk(1, 1, 4'd1, 1, 4'd3, 1, 4'd2, 0, 0, 1));
    step(s_nop); step(s_nop);
    // Load-use: LDR R4 then ADD R5,R4,#1.
    step(mk(1, 1, 4'd7, 0, 4'd0, 1, 4'd4, 1, 0, 1));
    repeat (3) step(mk(1, 1, 4'd4, 0, 4'd0, 1, 4'd5, 0, 0, 1));
    step(s_nop); step(s_nop);
    // Branch squash of a dependent instruction, then it returns after refetch.
    step(mk(1, 1, 4'd7, 0, 4'd0, 1, 4'd8, 0, 0, 1));
    step(mk(1, 1, 4'd8, 0, 4'd0, 1, 4'd9, 0, 1, 1));
    repeat (2) step(mk(1, 1, 4'd8, 0, 4'd0, 1, 4'd9, 0, 0, 1));
    // SRAM wait for 3 cycles in the middle of a RAW stall, then branch during freeze.
    step(mk(1, 1, 4'd0, 0, 4'd0, 1, 4'd10, 0, 0, 1));
    step(mk(1, 1, 4'd10, 0, 4'd0, 1, 4'd11, 0, 0, 0));
    repeat (2) step(mk(1, 1, 4'd10, 0, 4'd0, 1, 4'd11, 0, 0, 0));
    repeat (3) step(mk(1, 1, 4'd10, 0, 4'd0, 1, 4'd11, 0, 0, 1));
    step(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd12, 0, 1, 0));
    step(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd12, 0, 1, 1));
    // Two-source filtering against E.dest = R13.
    step(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd13, 0, 0, 1));
    step(mk(1, 1, 4'd2, 0, 4'd13, 1, 4'd14, 0, 0, 1));
    step(s_nop); step(s_nop);
    step(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd13, 1, 0, 1));
    step(mk(1, 1, 4'd2, 1, 4'd13, 1, 4'd14, 0, 0, 1));
    // Saturation: a producer in EXE/MEM stays visible while stalled only for 2 cycles,
    // so keep re-issuing producers and readers to rack up > 35 stall cycles.
    repeat (20) begin
      step(mk(1, 0, 4'd0, 0, 4'd0, 1, 4'd3, 1, 0, 1));
      step(mk(1, 1, 4'd3, 0, 4'd0, 1, 4'd6, 0, 0, 1));
      step(mk(1, 1, 4'd3, 0, 4'd0, 1, 4'd6, 0, 0, 1));
    end
    // Reset for one cycle: counter cleared, outputs low, scoreboard empty afterwards.
    step(mk(1, 1, 4'd6, 1, 4'd3, 1, 4'd6, 0, 1, 0));
    s_rst.valid = 1'b1; s_rst.s1_used = 1'b1; s_rst.s1 = 4'd3;
    step(s_rst);
    step(mk(1, 1, 4'd3, 1, 4'd6, 1, 4'd1, 0, 0, 1));

    // Randomised traffic over a small register window to make hits frequent.
    repeat (600) begin
      stim_t s;
      s = mk(1'($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom_range(0, 3)),
             1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 4) != 0));
      s.rst_n = 1'($urandom_range(0, 59) != 0);
      step(s);
    end

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
